// File: rtl/counter_sequencer.sv
// counter_sequencer: run-control FSM around an enable-gated up-counter.
// Adds start, pause/resume, abort, a latched terminal value, one-shot or
// periodic operation, a one-cycle done pulse and a saturating tally of
// completed intervals. Everything except busy is registered.

module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] periods
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] lim_q;
  logic             mode_q;

  // Sequencer FSM: abort beats pause beats start beats the terminal check.
  // The terminal compare is equality against the latched limit, so the
  // count never runs past lim_q and an all-ones limit cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count   <= '0;
      done    <= 1'b0;
      periods <= '0;
      lim_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (abort) begin
            count <= '0;
          end else if (start) begin
            lim_q   <= limit;
            mode_q  <= mode;
            count   <= '0;
            periods <= '0;
            state_q <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            count   <= '0;
            state_q <= IDLE;
          end else if (pause) begin
            state_q <= PAUSE;
          end else if (count == lim_q) begin
            done <= 1'b1;
            if (periods != ALL_ONES) begin
              periods <= periods + ONE;
            end
            if (mode_q) begin
              count <= '0;
            end else begin
              state_q <= DONE;
            end
          end else begin
            count <= count + ONE;
          end
        end

        PAUSE: begin
          if (abort) begin
            count   <= '0;
            state_q <= IDLE;
          end else if (start) begin
            state_q <= RUN;
          end
        end

        DONE: begin
          if (abort) begin
            count   <= '0;
            state_q <= IDLE;
          end else if (start) begin
            lim_q   <= limit;
            mode_q  <= mode;
            count   <= '0;
            periods <= '0;
            state_q <= RUN;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // busy is decoded straight from the state register so it tracks state
  // in the same cycle without an extra flop.
  always_comb begin
    busy = (state_q == RUN) || (state_q == PAUSE);
  end

  assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed testbench for counter_sequencer: one-shot, periodic, pause
// collision, abort priority, limit extremes, saturation and sync reset.

module tb_counter_sequencer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       abort;
  logic       mode;
  logic [7:0] limit;
  logic [7:0] count;
  logic [1:0] state;
  logic       busy;
  logic       done;
  logic [7:0] periods;

  int checks;
  int passed;
  int failures;

  counter_sequencer #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pause   (pause),
    .abort   (abort),
    .mode    (mode),
    .limit   (limit),
    .count   (count),
    .state   (state),
    .busy    (busy),
    .done    (done),
    .periods (periods)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the control inputs; called 1 ns after an edge so they are stable.
  task automatic applyStimulus(input logic st, input logic pa, input logic ab,
                               input logic md, input logic [7:0] lim);
    start = st;
    pause = pa;
    abort = ab;
    mode  = md;
    limit = lim;
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare every output at once against hand-computed values.
  task automatic checkOutput(input string tag, input logic [7:0] expCount,
                             input logic [1:0] expState, input logic expBusy,
                             input logic expDone, input logic [7:0] expPeriods);
    checks++;
    assert ({count, state, busy, done, periods} ===
            {expCount, expState, expBusy, expDone, expPeriods})
      passed++;
    else begin
      failures++;
      $error("[TB] FAIL %s: observed count=%0d state=%0d busy=%0b done=%0b periods=%0d, expected count=%0d state=%0d busy=%0b done=%0b periods=%0d",
             tag, count, state, busy, done, periods,
             expCount, expState, expBusy, expDone, expPeriods);
    end
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Reset held for two edges.
    tick(2);
    checkOutput("reset", 8'd0, S_IDLE, 1'b0, 1'b0, 8'd0);

    // One-shot, limit 5: count 0..5, done one cycle after count hits 5.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    tick(1);
    checkOutput("os_start", 8'd0, S_RUN, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      checkOutput($sformatf("os_count_%0d", k), 8'(k), S_RUN, 1'b1, 1'b0, 8'd0);
    end
    tick(1);
    checkOutput("os_done", 8'd5, S_DONE, 1'b0, 1'b1, 8'd1);
    tick(1);
    checkOutput("os_hold", 8'd5, S_DONE, 1'b0, 1'b0, 8'd1);

    // Periodic, limit 3: 4-cycle period; limit/mode changes mid-run ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    tick(1);
    checkOutput("per_start", 8'd0, S_RUN, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      checkOutput($sformatf("per_cycle_%0d", i), 8'(i % 4), S_RUN, 1'b1,
                  (i % 4 == 0), 8'(i / 4));
      if (i == 6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd9);
    end

    // Abort from RUN keeps the tally.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd9);
    tick(1);
    checkOutput("abort_run", 8'd0, S_IDLE, 1'b0, 1'b0, 8'd3);

    // Abort priority: periodic limit 9 with start held (ignored in RUN).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd9);
    tick(1);
    checkOutput("prio_start", 8'd0, S_RUN, 1'b1, 1'b0, 8'd0);
    tick(10);
    checkOutput("prio_wrap", 8'd0, S_RUN, 1'b1, 1'b1, 8'd1);
    tick(7);
    checkOutput("prio_at7", 8'd7, S_RUN, 1'b1, 1'b0, 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd9);
    tick(1);
    checkOutput("prio_abort", 8'd0, S_IDLE, 1'b0, 1'b0, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd9);
    tick(1);
    checkOutput("prio_idle_hold", 8'd0, S_IDLE, 1'b0, 1'b0, 8'd1);

    // Pause collides with the terminal count; done comes after resume.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    tick(1);
    checkOutput("pz_start", 8'd0, S_RUN, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    tick(4);
    checkOutput("pz_at4", 8'd4, S_RUN, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd100);
    tick(1);
    checkOutput("pz_pause1", 8'd4, S_PAUSE, 1'b1, 1'b0, 8'd0);
    tick(2);
    checkOutput("pz_pause3", 8'd4, S_PAUSE, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd100);
    tick(1);
    checkOutput("pz_resume", 8'd4, S_RUN, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd100);
    tick(1);
    checkOutput("pz_done", 8'd4, S_DONE, 1'b0, 1'b1, 8'd1);

    // Abort from DONE returns to IDLE but keeps periods.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    tick(1);
    checkOutput("abort_done", 8'd0, S_IDLE, 1'b0, 1'b0, 8'd1);

    // Limit 0 one-shot: done one cycle after entering RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    checkOutput("l0_os_start", 8'd0, S_RUN, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    checkOutput("l0_os_done", 8'd0, S_DONE, 1'b0, 1'b1, 8'd1);
    tick(1);
    checkOutput("l0_os_hold", 8'd0, S_DONE, 1'b0, 1'b0, 8'd1);

    // Limit 0 periodic: done every cycle; tally saturates at 255.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    tick(1);
    checkOutput("l0_per_start", 8'd0, S_RUN, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      checkOutput($sformatf("l0_per_%0d", i), 8'd0, S_RUN, 1'b1, 1'b1, 8'(i));
    end
    tick(252);
    checkOutput("sat_255", 8'd0, S_RUN, 1'b1, 1'b1, 8'd255);
    tick(45);
    checkOutput("sat_300", 8'd0, S_RUN, 1'b1, 1'b1, 8'd255);

    // Limit 255 periodic: full 256-cycle period, clean wrap to 0.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    tick(1);
    checkOutput("abort_sat", 8'd0, S_IDLE, 1'b0, 1'b0, 8'd255);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd255);
    tick(1);
    checkOutput("l255_start", 8'd0, S_RUN, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
    tick(255);
    checkOutput("l255_top", 8'd255, S_RUN, 1'b1, 1'b0, 8'd0);
    tick(1);
    checkOutput("l255_wrap1", 8'd0, S_RUN, 1'b1, 1'b1, 8'd1);
    tick(1);
    checkOutput("l255_after", 8'd1, S_RUN, 1'b1, 1'b0, 8'd1);
    tick(254);
    checkOutput("l255_top2", 8'd255, S_RUN, 1'b1, 1'b0, 8'd1);
    tick(1);
    checkOutput("l255_wrap2", 8'd0, S_RUN, 1'b1, 1'b1, 8'd2);

    // A reset glitch between edges is invisible; a sampled one clears all.
    tick(9);
    checkOutput("pre_glitch", 8'd9, S_RUN, 1'b1, 1'b0, 8'd2);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick(1);
    checkOutput("rst_glitch", 8'd10, S_RUN, 1'b1, 1'b0, 8'd2);
    rst = 1'b1;
    tick(1);
    checkOutput("rst_midrun", 8'd0, S_IDLE, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    tick(1);
    checkOutput("rst_release", 8'd0, S_IDLE, 1'b0, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run-control sequencer for the team's 8-bit enable-gated up-counter. It embeds the count register and wraps it in a small FSM that adds start, pause/resume, abort, a programmable terminal value, one-shot or periodic mode, a done pulse and a completed-period tally. It sits between the control/host logic and any block that needs timed intervals. It replaces ad-hoc gating of the bare counter's enable.

Parameters:
WIDTH, 8, width of count, limit and periods.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  start from IDLE/DONE; resume from PAUSE.
pause  in  1  freeze the count while in RUN.
abort  in  1  return to IDLE and clear the count.
mode  in  1  0 = one-shot, 1 = periodic; latched at start.
limit  in  WIDTH  terminal count value; latched at start.
count  out  WIDTH  current count value.
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
busy  out  1  high in RUN or PAUSE; combinational from state.
done  out  1  one-cycle pulse on reaching the terminal value.
periods  out  WIDTH  completed intervals; saturates at 2^WIDTH-1.

Behaviour:
- Reset: rst=1 at a clk edge forces state=IDLE, count=0, done=0, periods=0, and clears the latched limit and mode. Reset works from any state, including mid-run. There is no asynchronous path.
- All outputs are registered except busy.
- Priority within a cycle: rst > abort > pause > start > terminal evaluation.
- IDLE:
  - start=1: latch limit→lim_q and mode→mode_q, set count=0 and periods=0, go to RUN.
  - Otherwise hold.
- RUN, evaluated on each edge:
  - abort=1: go to IDLE, count=0, no done.
  - pause=1: go to PAUSE, count holds. This applies even when count==lim_q; the terminal is then evaluated on the first RUN cycle after resume.
  - count==lim_q and mode_q=0: done=1 next cycle, periods+1, go to DONE, count holds at lim_q.
  - count==lim_q and mode_q=1: done=1 next cycle, periods+1, count=0, stay in RUN.
  - Otherwise: count+1.
  - start is ignored in RUN.
- PAUSE:
  - abort=1: go to IDLE with count=0.
  - start=1: go to RUN with no count change.
  - pause and the limit input are ignored.
- DONE:
  - Holds count=lim_q and periods.
  - start=1: re-latch limit and mode, count=0, periods=0, go to RUN.
  - abort=1: go to IDLE, count=0. periods is kept; only rst or a new start clears it.
- Timing:
  - start is sampled at edge E0 and RUN begins after E0 with count=0.
  - count=k after edge E(k).
  - done is high during the cycle after E(L+1), where L=lim_q.
  - One-shot run length is L+1 counting cycles. Periodic period is L+1 cycles.
- limit=0:
  - One-shot: done asserts after E1 and the block goes to DONE with count=0.
  - Periodic: done pulses every cycle.
- Limit and mode changes while running have no effect until the next start.
- Arithmetic:
  - count never wraps past lim_q, so lim_q=2^WIDTH-1 counts the full range with no overflow.
  - periods increment saturates at 2^WIDTH-1.
- done pulse width:
  - Exactly one cycle in one-shot.
  - In periodic mode with limit≥1, pulses are separated by L low cycles.

Test Plan:
- Reset and basic one-shot: rst high for 2 cycles, then limit=5, mode=0, start pulse → count 0..5 in successive cycles; done=1 for one cycle immediately after count=5; state=DONE, count=5, periods=1, busy=0.
- Periodic with mid-run limit change: limit=3, mode=1, start, run 12 cycles, change limit to 9 at cycle 6 → done pulses every 4 cycles (3 pulses); count sequence 0,1,2,3,0,…; periods=3; new limit ignored.
- Pause/resume with collision: limit=4, pause asserted in the cycle count==4 and held 3 cycles, then start → count frozen at 4 with no done while paused; done pulses one cycle after resume; state=DONE.
- Abort priority: in RUN at count=7, assert abort+pause+start together → next cycle state=IDLE, count=0, no done; periods unchanged.
- Edge limits: limit=0 one-shot gives done one cycle after entering RUN. limit=255, mode=1 runs 256-cycle periods with no wrap glitch. Force 300 periods → periods saturates at 255.
- Synchronous reset mid-run: rst pulsed at count=10 → all outputs return to reset values on that edge only; a glitch on rst between edges has no effect.
